fan_ctrl_array: RTL and testbench

Parametrised multi-channel fan controller for the user project area. It generates NUM_CH PWM fan drives and measures per-channel tachometer speed. Each channel has a spin-up kick, manual or temperature-stepped automatic duty, and stall detection with a fault latch. It sits behind the wrapper's io pins: tach and temperature codes come in, and PWM, status and irq go out.

---
 rtl/fan_ctrl_pkg.sv | 15 +
 rtl/fan_channel.sv | 155 +++++++++++++++
 rtl/fan_ctrl_array.sv | 89 ++++++++
 tb/tb_fan_ctrl_array.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_ctrl_pkg.sv
// Shared types and constants for the multi-channel fan controller.
package fan_ctrl_pkg;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    KICK  = 3'd1,
    RUN   = 3'd2,
    RETRY = 3'd3,
    FAULT = 3'd4
  } ch_state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/fan_channel.sv
// One fan channel: sequencing FSM, applied duty, tach counting and PWM compare.
//
// state | meaning
// OFF   | channel idle, duty 0
// KICK  | spin-up, full duty for KICK_PER periods, no stall checking
// RUN   | manual or temperature-stepped duty, stall checking active
// RETRY | one re-kick after the first silent tach window
// FAULT | fan stalled twice in a row, duty 0 until stall_clr
module fan_channel
  import fan_ctrl_pkg::*;
#(
  parameter int DUTY_W   = 8,
  parameter int TEMP_W   = 8,
  parameter int CNT_W    = 12,
  parameter int KICK_PER = 4,
  parameter int MIN_DUTY = 32
) (
  input  logic              clk_sys,
  input  logic              rst_b,
  input  logic              wrap,
  input  logic              win_end,
  input  logic [DUTY_W-1:0] pcnt,
  input  logic              en,
  input  logic              mode,
  input  logic [DUTY_W-1:0] duty_req,
  input  logic [TEMP_W-1:0] temp,
  input  logic [TEMP_W-1:0] t_lo,
  input  logic [TEMP_W-1:0] t_hi,
  input  logic              tach,
  input  logic              stall_clr,
  output logic              pwm,
  output logic [CNT_W-1:0]  tach_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic              stall
);

  localparam logic [DUTY_W-1:0] DUTY_MAX  = '1;
  localparam logic [DUTY_W-1:0] DUTY_MIN  = DUTY_W'(MIN_DUTY);
  localparam int                KW        = $clog2(KICK_PER + 1);
  localparam logic [KW-1:0]     KICK_LOAD = KW'(KICK_PER);

  ch_state_t         state, state_nxt;
  logic [DUTY_W-1:0] duty_nxt, duty_auto;
  logic [KW-1:0]     kick_cnt, kick_nxt;
  logic              retry, retry_nxt;
  logic [2:0]        tach_sync;
  logic              tach_rise;
  logic [CNT_W-1:0]  edge_cnt;

  assign tach_rise = tach_sync[1] & ~tach_sync[2];
  assign stall     = (state == FAULT);

  // Synchronise tach, count rising edges, hand the count over at window end
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      tach_sync <= '0;
      edge_cnt  <= '0;
      tach_cnt  <= '0;
    end else begin
      tach_sync <= {tach_sync[1:0], tach};
      if (win_end) begin
        tach_cnt <= edge_cnt;
        edge_cnt <= {{(CNT_W-1){1'b0}}, tach_rise};
      end else if (tach_rise && edge_cnt != '1) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

  // One temperature step of the automatic duty; illegal thresholds hold
  always_comb begin
    duty_auto = duty;
    if (t_lo <= t_hi) begin
      if (temp > t_hi && duty != DUTY_MAX)
        duty_auto = duty + 1'b1;
      else if (temp < t_lo && duty > DUTY_MIN)
        duty_auto = duty - 1'b1;
    end
  end

  // Next state, next applied duty, kick timer and retry flag
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    kick_nxt  = kick_cnt;
    retry_nxt = retry;
    case (state)
      OFF: begin
        duty_nxt  = '0;
        retry_nxt = 1'b0;
        if (en) begin
          state_nxt = KICK;
          kick_nxt  = KICK_LOAD;
        end
      end
      KICK, RETRY: begin
        if (wrap) begin
          if (kick_cnt == '0) begin
            state_nxt = RUN;
            duty_nxt  = (mode == MODE_AUTO) ? DUTY_MIN : duty_req;
          end else begin
            duty_nxt = DUTY_MAX;
            kick_nxt = kick_cnt - 1'b1;
          end
        end
      end
      RUN: begin
        if (win_end && edge_cnt == '0 && duty != '0) begin
          if (retry) begin
            state_nxt = FAULT;
            duty_nxt  = '0;
          end else begin
            state_nxt = RETRY;
            retry_nxt = 1'b1;
            kick_nxt  = KICK_LOAD;
          end
        end else begin
          if (win_end) retry_nxt = 1'b0;
          if (wrap) duty_nxt = (mode == MODE_AUTO) ? duty_auto : duty_req;
        end
      end
      FAULT: begin
        duty_nxt = '0;
        if (stall_clr) state_nxt = OFF;
      end
      default: begin
        state_nxt = OFF;
        duty_nxt  = '0;
      end
    endcase
    // Disable drops duty at once; a latched fault outranks it
    if (!en && state != FAULT) begin
      state_nxt = OFF;
      duty_nxt  = '0;
    end
  end

  // Channel state and applied duty registers, plus registered PWM compare
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      state    <= OFF;
      duty     <= '0;
      kick_cnt <= '0;
      retry    <= 1'b0;
      pwm      <= 1'b0;
    end else begin
      state    <= state_nxt;
      duty     <= duty_nxt;
      kick_cnt <= kick_nxt;
      retry    <= retry_nxt;
      pwm      <= (pcnt < duty);
    end
  end

endmodule

// File: rtl/fan_ctrl_array.sv
// Multi-channel fan controller: shared timebases, per-channel fan_channel instances.
module fan_ctrl_array
  import fan_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DUTY_W   = 8,
  parameter int TEMP_W   = 8,
  parameter int PRESC_W  = 8,
  parameter int WIN_W    = 20,
  parameter int CNT_W    = 12,
  parameter int KICK_PER = 4,
  parameter int MIN_DUTY = 32
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic [NUM_CH-1:0]        en_i,
  input  logic [NUM_CH-1:0]        mode_i,
  input  logic [NUM_CH*DUTY_W-1:0] duty_i,
  input  logic [NUM_CH*TEMP_W-1:0] temp_i,
  input  logic [TEMP_W-1:0]        t_lo_i,
  input  logic [TEMP_W-1:0]        t_hi_i,
  input  logic [PRESC_W-1:0]       presc_i,
  input  logic [NUM_CH-1:0]        tach_i,
  input  logic [NUM_CH-1:0]        stall_clr_i,
  output logic [NUM_CH-1:0]        pwm_o,
  output logic [NUM_CH*CNT_W-1:0]  tach_cnt_o,
  output logic                     tach_vld_o,
  output logic [NUM_CH*DUTY_W-1:0] duty_o,
  output logic [NUM_CH-1:0]        stall_o,
  output logic                     irq_o
);

  // PWM counter runs 0 .. 2^DUTY_W-2 so the all-ones duty is always high
  localparam logic [DUTY_W-1:0] PCNT_LAST = {{(DUTY_W-1){1'b1}}, 1'b0};

  logic [PRESC_W-1:0] presc_cnt;
  logic [DUTY_W-1:0]  pcnt;
  logic [WIN_W-1:0]   win_cnt;
  logic               tick, wrap, win_end;

  assign tick    = (presc_cnt == '0);
  assign wrap    = tick && (pcnt == PCNT_LAST);
  assign win_end = &win_cnt;
  assign irq_o   = |stall_o;

  // Shared prescaler down-counter, PWM period counter and tach window
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      presc_cnt  <= '0;
      pcnt       <= '0;
      win_cnt    <= '0;
      tach_vld_o <= 1'b0;
    end else begin
      presc_cnt  <= tick ? presc_i : presc_cnt - 1'b1;
      if (tick) pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
      win_cnt    <= win_cnt + 1'b1;
      tach_vld_o <= win_end;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fan_channel #(
      .DUTY_W   (DUTY_W),
      .TEMP_W   (TEMP_W),
      .CNT_W    (CNT_W),
      .KICK_PER (KICK_PER),
      .MIN_DUTY (MIN_DUTY)
    ) u_ch (
      .clk_sys   (wb_clk_i),
      .rst_b     (wb_rst_ni),
      .wrap      (wrap),
      .win_end   (win_end),
      .pcnt      (pcnt),
      .en        (en_i[c]),
      .mode      (mode_i[c]),
      .duty_req  (duty_i[c*DUTY_W +: DUTY_W]),
      .temp      (temp_i[c*TEMP_W +: TEMP_W]),
      .t_lo      (t_lo_i),
      .t_hi      (t_hi_i),
      .tach      (tach_i[c]),
      .stall_clr (stall_clr_i[c]),
      .pwm       (pwm_o[c]),
      .tach_cnt  (tach_cnt_o[c*CNT_W +: CNT_W]),
      .duty      (duty_o[c*DUTY_W +: DUTY_W]),
      .stall     (stall_o[c])
    );
  end

endmodule

// File: tb/tb_fan_ctrl_array.sv
// Self-checking bench for fan_ctrl_array with a small behavioural duty model.
module tb_fan_ctrl_array;

  localparam int NUM_CH   = 2;
  localparam int DUTY_W   = 8;
  localparam int TEMP_W   = 8;
  localparam int PRESC_W  = 8;
  localparam int WIN_W    = 10;
  localparam int CNT_W    = 12;
  localparam int KICK_PER = 4;
  localparam int MIN_DUTY = 32;
  localparam int PERIOD   = (1 << DUTY_W) - 1;
  localparam int DMAX     = (1 << DUTY_W) - 1;
  localparam int WIN      = 1 << WIN_W;

  logic                     wb_clk_i = 1'b0;
  logic                     wb_rst_ni = 1'b0;
  logic [NUM_CH-1:0]        en_i = '0;
  logic [NUM_CH-1:0]        mode_i = '0;
  logic [NUM_CH*DUTY_W-1:0] duty_i = '0;
  logic [NUM_CH*TEMP_W-1:0] temp_i = '0;
  logic [TEMP_W-1:0]        t_lo_i = 8'd40;
  logic [TEMP_W-1:0]        t_hi_i = 8'd60;
  logic [PRESC_W-1:0]       presc_i = '0;
  logic [NUM_CH-1:0]        tach_i;
  logic [NUM_CH-1:0]        stall_clr_i = '0;
  logic [NUM_CH-1:0]        pwm_o;
  logic [NUM_CH*CNT_W-1:0]  tach_cnt_o;
  logic                     tach_vld_o;
  logic [NUM_CH*DUTY_W-1:0] duty_o;
  logic [NUM_CH-1:0]        stall_o;
  logic                     irq_o;

  logic tach0 = 1'b0, tach1 = 1'b0, tach_run = 1'b0;
  assign tach_i = {tach1, tach0};

  int checks = 0, failures = 0;

  fan_ctrl_array #(
    .NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .TEMP_W(TEMP_W), .PRESC_W(PRESC_W),
    .WIN_W(WIN_W), .CNT_W(CNT_W), .KICK_PER(KICK_PER), .MIN_DUTY(MIN_DUTY)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .en_i(en_i), .mode_i(mode_i),
    .duty_i(duty_i), .temp_i(temp_i), .t_lo_i(t_lo_i), .t_hi_i(t_hi_i),
    .presc_i(presc_i), .tach_i(tach_i), .stall_clr_i(stall_clr_i),
    .pwm_o(pwm_o), .tach_cnt_o(tach_cnt_o), .tach_vld_o(tach_vld_o),
    .duty_o(duty_o), .stall_o(stall_o), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Free-running tach for channel 0: one rising edge every 20 clocks while enabled
  initial begin
    forever begin
      repeat (10) @(posedge wb_clk_i);
      #2;
      tach0 = tach_run ? ~tach0 : 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tk();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tk();
  endtask

  function automatic int dty(input int ch);
    return int'(duty_o[ch*DUTY_W +: DUTY_W]);
  endfunction

  function automatic int cnt1();
    return int'(tach_cnt_o[CNT_W +: CNT_W]);
  endfunction

  // Expected duty after one period in auto mode, straight from the temperature rules
  function automatic int auto_next(input int d, input int t, input int lo, input int hi);
    if (lo > hi) return d;
    if (t > hi) return (d + 1 > DMAX) ? DMAX : d + 1;
    if (t < lo) return (d - 1 < MIN_DUTY) ? d : d - 1;
    return d;
  endfunction

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      tk();
      if (pwm_o[ch]) hi++;
    end
  endtask

  task automatic wait_duty(input int ch, input int val, input int bound, output int n);
    n = 0;
    while (dty(ch) != val && n < bound) begin
      tk();
      n++;
    end
  endtask

  task automatic wait_vld(input int bound, output int n);
    n = 0;
    do begin
      tk();
      n++;
    end while (!tach_vld_o && n < bound);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_pwm"}, 32'(pwm_o), 0);
    chk({pfx, "_tcnt"}, 32'(tach_cnt_o), 0);
    chk({pfx, "_vld"}, 32'(tach_vld_o), 0);
    chk({pfx, "_duty"}, 32'(duty_o), 0);
    chk({pfx, "_stall"}, 32'(stall_o), 0);
    chk({pfx, "_irq"}, 32'(irq_o), 0);
  endtask

  task automatic set_duty0(input int d);
    duty_i[DUTY_W-1:0] = DUTY_W'(d);
  endtask

  task automatic set_temp0(input int t);
    temp_i[TEMP_W-1:0] = TEMP_W'(t);
  endtask

  initial begin
    int n, hi, d, p, model, lo, hh, tmp;
    bit early;

    #3;
    chk_all_zero("reset");
    ticks(3);
    wb_rst_ni = 1'b1;
    ticks(2);

    // Spin-up kick followed by manual duty 64
    tach_run = 1'b1;
    set_duty0(64);
    en_i[0] = 1'b1;
    n = 0;
    while (!pwm_o[0] && n < 600) begin tk(); n++; end
    chk("kick_start", 32'(n < 600), 1);
    n = 0;
    while (pwm_o[0] && n < 3000) begin tk(); n++; end
    chk("kick_run_len", n, KICK_PER * PERIOD + 64);
    chk("run_duty64", dty(0), 64);
    count_high(0, PERIOD, hi);
    chk("run_high64", hi, 64);

    // Random manual duties: high time per period equals the duty
    for (int i = 0; i < 3; i++) begin
      d = int'($urandom_range(1, DMAX - 1));
      set_duty0(d);
      wait_duty(0, d, 300, n);
      chk("man_duty_load", dty(0), d);
      ticks(2);
      count_high(0, PERIOD, hi);
      chk("man_high", hi, d);
    end

    // Extremes: constant low and constant high across three periods
    set_duty0(0);
    wait_duty(0, 0, 300, n);
    chk("duty0_load", dty(0), 0);
    ticks(2);
    count_high(0, 3 * PERIOD, hi);
    chk("duty0_high", hi, 0);
    set_duty0(DMAX);
    wait_duty(0, DMAX, 300, n);
    chk("dutymax_load", dty(0), DMAX);
    ticks(2);
    count_high(0, 3 * PERIOD, hi);
    chk("dutymax_high", hi, 3 * PERIOD);

    // Mid-period duty change is held off until the wrap
    set_duty0(100);
    wait_duty(0, 100, 300, n);
    ticks(100);
    set_duty0(150);
    wait_duty(0, 150, 400, n);
    chk("mid_change_delay", n, PERIOD - 100);

    // Tach window timing and per-window counts on channel 1
    wait_vld(WIN + 100, n);
    chk("vld_found", 32'(tach_vld_o), 1);
    wait_vld(WIN + 100, n);
    chk("vld_period", n, WIN);
    for (int k = 0; k < 3; k++) begin
      p = (k == 0) ? 100 : int'($urandom_range(1, 100));
      repeat (p) begin
        tach1 = 1'b1; ticks(5);
        tach1 = 1'b0; ticks(5);
      end
      wait_vld(WIN + 100, n);
      chk("tach_vld_seen", 32'(tach_vld_o), 1);
      chk("tach_cnt_ch1", cnt1(), p);
    end
    // Edge landing on the window-end cycle belongs to the following window
    ticks(WIN - 3);
    tach1 = 1'b1;
    wait_vld(20, n);
    chk("bnd_old_window", cnt1(), 0);
    ticks(5);
    tach1 = 1'b0;
    wait_vld(WIN + 100, n);
    chk("bnd_new_window", cnt1(), 1);

    // Disable forces duty to zero without waiting for the period
    en_i[0] = 1'b0;
    tk();
    chk("dis_duty_now", dty(0), 0);
    tk();
    chk("dis_pwm", 32'(pwm_o[0]), 0);

    // Auto mode from MIN_DUTY, stepping once per period
    lo = 40; hh = 60; tmp = 70;
    t_lo_i = 8'(lo); t_hi_i = 8'(hh);
    mode_i[0] = 1'b1;
    set_temp0(tmp);
    en_i[0] = 1'b1;
    wait_duty(0, MIN_DUTY, 2500, n);
    ticks(PERIOD / 2);
    model = MIN_DUTY;
    chk("auto_entry", dty(0), model);
    for (int i = 0; i < 5; i++) begin
      ticks(PERIOD);
      model = auto_next(model, tmp, lo, hh);
      chk("auto_rise", dty(0), model);
    end
    tmp = 50; set_temp0(tmp);
    for (int i = 0; i < 2; i++) begin
      ticks(PERIOD);
      model = auto_next(model, tmp, lo, hh);
      chk("auto_hold", dty(0), model);
    end
    tmp = 70; set_temp0(tmp);
    lo = 60; hh = 40;
    t_lo_i = 8'(lo); t_hi_i = 8'(hh);
    for (int i = 0; i < 2; i++) begin
      ticks(PERIOD);
      model = auto_next(model, tmp, lo, hh);
      chk("auto_illegal", dty(0), model);
    end
    lo = 40; hh = 60;
    t_lo_i = 8'(lo); t_hi_i = 8'(hh);

    // Top saturation via manual 250 then auto
    mode_i[0] = 1'b0; set_duty0(250);
    ticks(PERIOD);
    model = 250;
    chk("auto_pre_top", dty(0), model);
    mode_i[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ticks(PERIOD);
      model = auto_next(model, tmp, lo, hh);
      chk("auto_top", dty(0), model);
    end
    tmp = 30; set_temp0(tmp);
    for (int i = 0; i < 3; i++) begin
      ticks(PERIOD);
      model = auto_next(model, tmp, lo, hh);
      chk("auto_fall", dty(0), model);
    end
    mode_i[0] = 1'b0; set_duty0(34);
    ticks(PERIOD);
    model = 34;
    chk("auto_pre_floor", dty(0), model);
    mode_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ticks(PERIOD);
      model = auto_next(model, tmp, lo, hh);
      chk("auto_floor", dty(0), model);
    end

    // Silent tach: first zero window re-kicks, second latches the fault
    mode_i[0] = 1'b0; set_duty0(64);
    ticks(PERIOD);
    chk("stall_pre_duty", dty(0), 64);
    tach_run = 1'b0;
    early = 1'b0;
    n = 0;
    while (dty(0) != DMAX && n < 3000) begin
      tk(); n++;
      if (stall_o[0]) early = 1'b1;
    end
    chk("retry_kick", dty(0), DMAX);
    chk("no_early_fault", 32'(early), 0);
    n = 0;
    while (!stall_o[0] && n < 3000) begin tk(); n++; end
    chk("fault_stall", 32'(stall_o[0]), 1);
    ticks(2);
    chk("fault_pwm", 32'(pwm_o[0]), 0);
    chk("fault_irq", 32'(irq_o), 1);
    chk("fault_duty", dty(0), 0);
    en_i[0] = 1'b0;
    ticks(5);
    chk("fault_beats_en", 32'(stall_o[0]), 1);
    en_i[0] = 1'b1;
    stall_clr_i[0] = 1'b1;
    tk();
    stall_clr_i[0] = 1'b0;
    chk("clr_stall", 32'(stall_o[0]), 0);
    chk("clr_irq", 32'(irq_o), 0);
    tach_run = 1'b1;
    wait_duty(0, DMAX, 600, n);
    chk("clr_rekick", dty(0), DMAX);

    // Asynchronous reset in the middle of the kick
    n = 0;
    while (!pwm_o[0] && n < 600) begin tk(); n++; end
    ticks(10);
    chk("pre_rst_pwm", 32'(pwm_o[0]), 1);
    #2;
    wb_rst_ni = 1'b0;
    #1;
    chk_all_zero("async_rst");
    ticks(3);
    wb_rst_ni = 1'b1;
    tk();
    chk("post_rst_duty", dty(0), 0);
    wait_duty(0, DMAX, 600, n);
    chk("post_rst_kick", dty(0), DMAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
